multicycle_ctrl_fsm: RTL

//  Main control state machine for the multiple-cycle datapath. It sequences instruction fetch,

---
 rtl/ctrl_pkg.sv | 75 +++++++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/multicycle_ctrl_fsm.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared constants and types for the multicycle control FSM:
//            state encodings, opcodes, ALU-op and mux-select codes, and the
//            packed control-signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

   // State encodings (4-bit; 13 and 14 are unused)
   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;
   localparam logic [3:0] S_JUMP   = 4'd12;
   localparam logic [3:0] S_TRAP   = 4'd15;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU operation select
   localparam logic [1:0] c_ALU_ADD   = 2'b00;
   localparam logic [1:0] c_ALU_SUB   = 2'b01;
   localparam logic [1:0] c_ALU_FUNCT = 2'b10;

   // PC source select
   localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
   localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

   // ALU operand B select
   localparam logic [1:0] c_SRCB_REGB  = 2'b00;
   localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
   localparam logic [1:0] c_SRCB_IMM   = 2'b10;
   localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

   // Control bundle produced by the output decoder
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       trap;
   } ctrl_sig_t;

   // States that wait on the memory handshake and are timed by the wait counter
   function automatic logic is_wait_state(input logic [3:0] s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Brief    : Counts cycles spent waiting for mem_ready within one memory
//            access. Clear has priority over enable. timeout_o flags that the
//            count has reached MEM_TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int WAIT_W      = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              en_i,
   output logic [WAIT_W-1:0] wait_cnt_o,
   output logic              timeout_o
);

   localparam logic [WAIT_W-1:0] c_LIMIT = WAIT_W'(MEM_TIMEOUT);

   logic [WAIT_W-1:0] wait_cnt_q;

   // Wait counter: cleared on access entry, saturates at the limit so it never wraps
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt_q <= '0;
      end else if (clr_i) begin
         wait_cnt_q <= '0;
      end else if (en_i && (wait_cnt_q != c_LIMIT)) begin
         wait_cnt_q <= wait_cnt_q + 1'b1;
      end
   end

   assign wait_cnt_o = wait_cnt_q;
   assign timeout_o  = (wait_cnt_q == c_LIMIT);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Brief    : Main control FSM of the multicycle datapath. Sequences fetch,
//            decode, execute, memory and writeback; drives datapath strobes
//            and mux selects; traps on illegal opcodes or memory timeout;
//            counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_source,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             trap,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] retired
);

   localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   logic [3:0]       state_q;
   logic [3:0]       state_d;
   logic             retire;
   logic [CNT_W-1:0] retired_q;
   logic             timer_clr;
   logic             timer_en;
   logic             timeout;
   logic [WAIT_W-1:0] wait_cnt;
   ctrl_sig_t        ctl;

   // Clear the timer whenever a memory-waiting state is freshly entered;
   // count only while that state is still waiting on mem_ready.
   assign timer_clr = (state_d != state_q) && is_wait_state(state_d);
   assign timer_en  = is_wait_state(state_q) && !mem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .WAIT_W      (WAIT_W)
   ) u_mem_wait_timer (
      .clock      (clock),
      .reset      (reset),
      .clr_i      (timer_clr),
      .en_i       (timer_en),
      .wait_cnt_o (wait_cnt),
      .timeout_o  (timeout)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and retire detection; mem_ready beats timeout on the same cycle
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ready)    state_d = S_DECODE;
            else if (timeout) state_d = S_TRAP;
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            if (mem_ready)    state_d = S_MEMWB;
            else if (timeout) state_d = S_TRAP;
         end
         S_MEMWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_MEMWR: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end else if (timeout) begin
               state_d = S_TRAP;
            end
         end
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_BRANCH: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_TRAP:   state_d = S_TRAP;
         // Unused encodings are treated as a fault
         default:  state_d = S_TRAP;
      endcase
   end

   // Output decode from the state register; fetch gates IR/PC load on mem_ready
   always_comb begin
      ctl = '0;
      case (state_q)
         S_FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = c_SRCB_FOUR;
            ctl.ir_write  = mem_ready;
            ctl.pc_write  = mem_ready;
            ctl.pc_source = c_PCSRC_ALU;
         end
         S_DECODE: begin
            ctl.alu_src_b = c_SRCB_IMMSH;
         end
         S_MEMADR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = c_SRCB_IMM;
         end
         S_MEMRD: begin
            ctl.mem_read = 1'b1;
            ctl.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            ctl.mem_to_reg = 1'b1;
            ctl.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            ctl.mem_write = 1'b1;
            ctl.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = c_SRCB_REGB;
            ctl.alu_op    = c_ALU_FUNCT;
         end
         S_ALUWB: begin
            ctl.reg_dst   = 1'b1;
            ctl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctl.alu_src_a     = 1'b1;
            ctl.alu_op        = c_ALU_SUB;
            ctl.pc_write_cond = 1'b1;
            ctl.pc_source     = c_PCSRC_ALUOUT;
         end
         S_ADDIEX: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = c_SRCB_IMM;
            ctl.alu_op    = c_ALU_ADD;
         end
         S_ADDIWB: begin
            ctl.reg_write = 1'b1;
         end
         S_JUMP: begin
            ctl.pc_write  = 1'b1;
            ctl.pc_source = c_PCSRC_JUMP;
         end
         S_TRAP: begin
            ctl.trap = 1'b1;
         end
         default: ctl = '0;
      endcase
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clock) begin
      if (reset) begin
         retired_q <= '0;
      end else if (retire) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign pc_write      = ctl.pc_write;
   assign pc_write_cond = ctl.pc_write_cond;
   assign pc_source     = ctl.pc_source;
   assign i_or_d        = ctl.i_or_d;
   assign mem_read      = ctl.mem_read;
   assign mem_write     = ctl.mem_write;
   assign ir_write      = ctl.ir_write;
   assign reg_dst       = ctl.reg_dst;
   assign mem_to_reg    = ctl.mem_to_reg;
   assign reg_write     = ctl.reg_write;
   assign alu_src_a     = ctl.alu_src_a;
   assign alu_src_b     = ctl.alu_src_b;
   assign alu_op        = ctl.alu_op;
   assign trap          = ctl.trap;
   assign state_o       = state_q;
   assign retired       = retired_q;

   // The debug count itself is observed only through the timeout flag
   logic unused_wait_cnt;
   assign unused_wait_cnt = ^wait_cnt;

endmodule : multicycle_ctrl_fsm
`default_nettype wire
